// File: rtl/mcu_sequencer.sv
// Purpose : frame sequencer for the 2D-conv engine; drives the MCU mux array and the N+2 column banks (LOAD/PROC/OUT).
// Latency : every output is registered, so a decision made at an edge is visible the following cycle; PROC is H+CONV_LAT cycles.
// Backpres: LOAD accepts one word per cycle while i_inValid is high; OUT holds address and valid while i_outReady is low.
//
// Ports:
//   i_CLK, i_reset          clock, synchronous active-high reset
//   i_start, i_numCols      frame start pulse and column count (sampled in IDLE only)
//   i_inValid / o_inReady   host input handshake (LOAD only)
//   o_outValid / i_outReady host result handshake (OUT only)
//   o_state, o_substate     mux state (00 LOAD, 01 PROC, 10 OUT, 11 IDLE) and bank-pair select
//   o_memSelect             mux bank select for LOAD/OUT
//   o_rdAddr, o_wrAddr      bank read/write address
//   o_wrEnable              per-bank write enable, bit b = bank b
//   o_busy, o_done          high outside IDLE; one-cycle pulse when the frame ends
module mcu_sequencer #(
  parameter int N            = 2,
  parameter int BITS_IMAGEN  = 11,
  parameter int IMAGE_HEIGHT = 440,
  parameter int BITS_ADDR    = $clog2(IMAGE_HEIGHT),
  parameter int BITS_COLS    = 10,
  parameter int CONV_LAT     = 3
) (
  input  logic                 i_CLK,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [BITS_COLS-1:0] i_numCols,
  input  logic                 i_inValid,
  output logic                 o_inReady,
  output logic                 o_outValid,
  input  logic                 i_outReady,
  output logic [1:0]           o_state,
  output logic                 o_substate,
  output logic [1:0]           o_memSelect,
  output logic [BITS_ADDR-1:0] o_rdAddr,
  output logic [BITS_ADDR-1:0] o_wrAddr,
  output logic [N+1:0]         o_wrEnable,
  output logic                 o_busy,
  output logic                 o_done
);

  // The bank-pair masks and 2-bit bank counter assume four banks. The pixel
  // word itself travels on a separate host data path and is not seen here.
  if (N != 2 || CONV_LAT < 1 || BITS_IMAGEN < 1) begin : g_param_check
    $error("mcu_sequencer: only N=2, CONV_LAT>=1 supported");
  end

  // PROC cycle counter runs 0 .. H+CONV_LAT-1.
  localparam int PROC_LEN = IMAGE_HEIGHT + CONV_LAT;
  localparam int CNT_W    = $clog2(PROC_LEN + 1);

  localparam logic [BITS_ADDR-1:0] LAST_ROW  = BITS_ADDR'(IMAGE_HEIGHT - 1);
  localparam logic [CNT_W-1:0]     PROC_LAST = CNT_W'(PROC_LEN - 1);
  localparam logic [CNT_W-1:0]     H_CNT     = CNT_W'(IMAGE_HEIGHT);
  localparam logic [CNT_W-1:0]     LAT_CNT   = CNT_W'(CONV_LAT);

  // Encodings match the mux array's state input so o_state is the register itself.
  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_PROC = 2'b01,
    S_OUT  = 2'b10,
    S_IDLE = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [BITS_ADDR-1:0] row_q, row_d;
  logic [1:0]           bank_q, bank_d;
  logic [1:0]           last_bank_q, last_bank_d;   // final bank of the current LOAD
  logic [BITS_COLS-1:0] cols_loaded_q, cols_loaded_d;
  logic [BITS_COLS-1:0] num_cols_q, num_cols_d;
  logic                 sub_q, sub_d;
  logic [CNT_W-1:0]     proc_cnt_q, proc_cnt_d;
  logic [CNT_W-1:0]     proc_inc;

  logic [1:0]           mem_select_q, mem_select_d;
  logic [BITS_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic [BITS_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [N+1:0]         wr_en_q, wr_en_d;
  logic                 in_rdy_q, in_rdy_d;
  logic                 out_vld_q, out_vld_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign proc_inc = proc_cnt_q + CNT_W'(1);

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      bank_q        <= '0;
      last_bank_q   <= '0;
      cols_loaded_q <= '0;
      num_cols_q    <= '0;
      sub_q         <= 1'b0;
      proc_cnt_q    <= '0;
      mem_select_q  <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      wr_en_q       <= '0;
      in_rdy_q      <= 1'b0;
      out_vld_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      bank_q        <= bank_d;
      last_bank_q   <= last_bank_d;
      cols_loaded_q <= cols_loaded_d;
      num_cols_q    <= num_cols_d;
      sub_q         <= sub_d;
      proc_cnt_q    <= proc_cnt_d;
      mem_select_q  <= mem_select_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_en_q       <= wr_en_d;
      in_rdy_q      <= in_rdy_d;
      out_vld_q     <= out_vld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    bank_d        = bank_q;
    last_bank_d   = last_bank_q;
    cols_loaded_d = cols_loaded_q;
    num_cols_d    = num_cols_q;
    sub_d         = sub_q;
    proc_cnt_d    = proc_cnt_q;
    mem_select_d  = mem_select_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_en_d       = '0;           // write enables are single-cycle strobes
    in_rdy_d      = in_rdy_q;
    out_vld_d     = out_vld_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Odd or short frames cannot be split into bank pairs; ignore them.
        if (i_start && !i_numCols[0] && (i_numCols >= BITS_COLS'(4))) begin
          state_d       = S_LOAD;
          num_cols_d    = i_numCols;
          cols_loaded_d = '0;
          sub_d         = 1'b0;
          bank_d        = 2'd0;
          last_bank_d   = 2'd3;
          row_d         = '0;
          in_rdy_d      = 1'b1;
          busy_d        = 1'b1;
        end
      end

      S_LOAD: begin
        if (i_inValid && in_rdy_q) begin
          // Strobe lands one cycle after acceptance, alongside the registered word.
          wr_en_d      = (N + 2)'(1) << bank_q;
          wr_addr_d    = row_q;
          mem_select_d = bank_q;
          if (row_q == LAST_ROW) begin
            row_d         = '0;
            bank_d        = bank_q + 2'd1;
            cols_loaded_d = cols_loaded_q + 1'b1;
            if (bank_q == last_bank_q) begin
              state_d    = S_PROC;
              in_rdy_d   = 1'b0;
              rd_addr_d  = '0;
              proc_cnt_d = '0;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      S_PROC: begin
        if (proc_cnt_q == PROC_LAST) begin
          state_d      = S_OUT;
          bank_d       = {sub_q, 1'b0};
          mem_select_d = {sub_q, 1'b0};
          row_d        = '0;
          rd_addr_d    = '0;
          out_vld_d    = 1'b0;
        end else begin
          proc_cnt_d = proc_inc;
          // Read address stops advancing at H-1; the tail covers convolver latency.
          if (proc_inc < H_CNT) begin
            rd_addr_d = proc_inc[BITS_ADDR-1:0];
          end
          // Result for read address k arrives CONV_LAT cycles later; overwrite the
          // consumed pair (banks 0/1 when sub=0, banks 2/3 when sub=1).
          if (proc_inc >= LAT_CNT) begin
            wr_en_d   = sub_q ? (N + 2)'(4'b1100) : (N + 2)'(4'b0011);
            wr_addr_d = BITS_ADDR'(proc_inc - LAT_CNT);
          end
        end
      end

      S_OUT: begin
        if (!out_vld_q) begin
          // Address was presented last cycle; bank data is now at the mux.
          out_vld_d = 1'b1;
        end else if (i_outReady) begin
          out_vld_d = 1'b0;
          if (row_q == LAST_ROW) begin
            if (bank_q[0]) begin
              // Second bank of the pair drained.
              if (cols_loaded_q < num_cols_q) begin
                state_d     = S_LOAD;
                sub_d       = !sub_q;
                bank_d      = {bank_q[1], 1'b0};
                last_bank_d = bank_q;
                row_d       = '0;
                in_rdy_d    = 1'b1;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              bank_d       = bank_q + 2'd1;
              mem_select_d = bank_q + 2'd1;
              row_d        = '0;
              rd_addr_d    = '0;
            end
          end else begin
            row_d     = row_q + 1'b1;
            rd_addr_d = row_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_state     = state_q;
  assign o_substate  = sub_q;
  assign o_memSelect = mem_select_q;
  assign o_rdAddr    = rd_addr_q;
  assign o_wrAddr    = wr_addr_q;
  assign o_wrEnable  = wr_en_q;
  assign o_inReady   = in_rdy_q;
  assign o_outValid  = out_vld_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Purpose : self-checking bench for mcu_sequencer with H=4, CONV_LAT=3.
// Latency : expected write/read events are queued per frame and popped as the DUT produces them.
// Backpres: exercises toggling i_inValid and a 5-cycle i_outReady stall.
module tb_mcu_sequencer;

  localparam int H  = 4;
  localparam int CL = 3;
  localparam int BA = 2;
  localparam int BC = 10;

  logic          i_CLK = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic [BC-1:0] i_numCols = '0;
  logic          i_inValid = 1'b0;
  logic          o_inReady;
  logic          o_outValid;
  logic          i_outReady = 1'b0;
  logic [1:0]    o_state;
  logic          o_substate;
  logic [1:0]    o_memSelect;
  logic [BA-1:0] o_rdAddr;
  logic [BA-1:0] o_wrAddr;
  logic [3:0]    o_wrEnable;
  logic          o_busy;
  logic          o_done;

  mcu_sequencer #(
    .N(2), .BITS_IMAGEN(11), .IMAGE_HEIGHT(H), .BITS_ADDR(BA), .BITS_COLS(BC), .CONV_LAT(CL)
  ) dut (
    .i_CLK(i_CLK), .i_reset(i_reset), .i_start(i_start), .i_numCols(i_numCols),
    .i_inValid(i_inValid), .o_inReady(o_inReady), .o_outValid(o_outValid),
    .i_outReady(i_outReady), .o_state(o_state), .o_substate(o_substate),
    .o_memSelect(o_memSelect), .o_rdAddr(o_rdAddr), .o_wrAddr(o_wrAddr),
    .o_wrEnable(o_wrEnable), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_CLK = ~i_CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] wq[$];   // {wr_enable, wr_addr}
  logic [5:0] rq[$];   // {state, mem_select, rd_addr} at each accepted output word
  bit mon_en = 1'b0;
  int proc_len = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected event streams for one legal frame of 'cols' columns.
  task automatic push_frame(input int cols);
    logic [3:0] m;
    logic [1:0] a;
    logic [1:0] bk;
    int passes;
    int sub;
    passes = (cols - 2) / 2;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < H; r++) begin
        m = 4'b0001 << b;
        a = 2'(r);
        wq.push_back({m, a});
      end
    for (int p = 0; p < passes; p++) begin
      sub = p % 2;
      for (int r = 0; r < H; r++) begin
        m = (sub == 1) ? 4'b1100 : 4'b0011;
        a = 2'(r);
        wq.push_back({m, a});
      end
      for (int b = 2 * sub; b < 2 * sub + 2; b++)
        for (int r = 0; r < H; r++) begin
          bk = 2'(b);
          a  = 2'(r);
          rq.push_back({2'b10, bk, a});
        end
      if (p != passes - 1)
        for (int b = 2 * sub; b < 2 * sub + 2; b++)
          for (int r = 0; r < H; r++) begin
            m = 4'b0001 << b;
            a = 2'(r);
            wq.push_back({m, a});
          end
    end
  endtask

  always @(negedge i_CLK) begin
    if (mon_en) begin
      if (o_wrEnable != 4'b0000) begin
        if (wq.size() == 0) check_eq("wr_unexpected", {26'd0, o_wrEnable, o_wrAddr}, 32'd0);
        else                check_eq("wr_event", {26'd0, o_wrEnable, o_wrAddr}, {26'd0, wq.pop_front()});
      end
      if (o_outValid && i_outReady) begin
        if (rq.size() == 0) check_eq("rd_unexpected", {26'd0, o_state, o_memSelect, o_rdAddr}, 32'd0);
        else                check_eq("rd_event", {26'd0, o_state, o_memSelect, o_rdAddr}, {26'd0, rq.pop_front()});
      end
    end
    if (o_state == 2'b01) proc_len++;
    else begin
      if (proc_len != 0 && mon_en) check_eq("proc_len", proc_len, H + CL);
      proc_len = 0;
    end
  end

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_state"},  o_state, 2'b11);
    check_eq({pfx, "_sub"},    o_substate, 0);
    check_eq({pfx, "_msel"},   o_memSelect, 0);
    check_eq({pfx, "_rdaddr"}, o_rdAddr, 0);
    check_eq({pfx, "_wraddr"}, o_wrAddr, 0);
    check_eq({pfx, "_wren"},   o_wrEnable, 0);
    check_eq({pfx, "_inrdy"},  o_inReady, 0);
    check_eq({pfx, "_outvld"}, o_outValid, 0);
    check_eq({pfx, "_busy"},   o_busy, 0);
    check_eq({pfx, "_done"},   o_done, 0);
  endtask

  task automatic try_bad_start(input int cols);
    i_numCols = BC'(cols);
    i_start = 1'b1;
    @(posedge i_CLK); #1;
    i_start = 1'b0;
    repeat (2) begin @(posedge i_CLK); #1; end
    check_eq("bad_start_state", o_state, 2'b11);
    check_eq("bad_start_busy", o_busy, 0);
    check_eq("bad_start_inrdy", o_inReady, 0);
  endtask

  task automatic run_frame(input int cols, input bit tog_in, input bit stall_out, input bit start_in_proc);
    bit seen_done;
    bit stalled;
    bit poked;
    logic [BA-1:0] ra;
    logic [1:0] ms;
    seen_done = 1'b0;
    stalled = 1'b0;
    poked = 1'b0;
    push_frame(cols);
    i_inValid = 1'b1;
    i_outReady = 1'b1;
    i_numCols = BC'(cols);
    i_start = 1'b1;
    @(posedge i_CLK); #1;
    i_start = 1'b0;
    check_eq("frame_state_load", o_state, 2'b00);
    check_eq("frame_busy", o_busy, 1);
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      @(posedge i_CLK); #1;
      i_start = 1'b0;
      if (o_done) seen_done = 1'b1;
      else begin
        if (tog_in) i_inValid = ~i_inValid;
        if (start_in_proc && !poked && o_state == 2'b01) begin
          i_start = 1'b1;
          i_numCols = BC'(8);
          poked = 1'b1;
        end
        if (stall_out && !stalled && o_state == 2'b10 && o_outValid) begin
          stalled = 1'b1;
          ra = o_rdAddr;
          ms = o_memSelect;
          i_outReady = 1'b0;
          repeat (5) begin
            @(posedge i_CLK); #1;
            check_eq("stall_rdaddr", o_rdAddr, ra);
            check_eq("stall_msel", o_memSelect, ms);
            check_eq("stall_outvld", o_outValid, 1);
          end
          i_outReady = 1'b1;
        end
      end
    end
    check_eq("done_pulse", o_done, 1);
    check_eq("done_state", o_state, 2'b11);
    check_eq("wr_left", wq.size(), 0);
    check_eq("rd_left", rq.size(), 0);
    i_inValid = 1'b0;
    @(posedge i_CLK); #1;
    check_eq("done_one_cycle", o_done, 0);
    check_eq("idle_busy", o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    // Reset with random inputs.
    i_reset = 1'b1;
    repeat (3) begin
      i_start    = 1'($urandom_range(0, 1));
      i_numCols  = BC'($urandom_range(0, 1023));
      i_inValid  = 1'($urandom_range(0, 1));
      i_outReady = 1'($urandom_range(0, 1));
      @(posedge i_CLK); #1;
    end
    check_reset("rst");
    i_reset = 1'b0;
    i_start = 1'b0;
    i_inValid = 1'b0;
    i_outReady = 1'b0;
    mon_en = 1'b1;

    try_bad_start(5);
    try_bad_start(2);

    run_frame(4, 1'b0, 1'b0, 1'b0);
    run_frame(6, 1'b0, 1'b0, 1'b0);
    run_frame(6, 1'b1, 1'b1, 1'b0);
    run_frame(6, 1'b0, 1'b0, 1'b1);

    // Reset during PROC cycle 4.
    push_frame(4);
    i_inValid = 1'b1;
    i_outReady = 1'b1;
    i_numCols = BC'(4);
    i_start = 1'b1;
    @(posedge i_CLK); #1;
    i_start = 1'b0;
    wait_cnt = 0;
    while (o_state != 2'b01 && wait_cnt < 200) begin
      @(posedge i_CLK); #1;
      wait_cnt++;
    end
    check_eq("proc_reached", o_state, 2'b01);
    repeat (4) begin @(posedge i_CLK); #1; end
    check_eq("proc_c4_wren", o_wrEnable, 4'b0011);
    check_eq("proc_c4_wraddr", o_wrAddr, 1);
    mon_en = 1'b0;
    i_reset = 1'b1;
    @(posedge i_CLK); #1;
    check_reset("mid_rst");
    i_reset = 1'b0;
    i_inValid = 1'b0;
    wq.delete();
    rq.delete();
    @(posedge i_CLK); #1;
    mon_en = 1'b1;
    run_frame(4, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
